// File: rtl/target_gen_lfsr.sv
// Target generator: a free-running Fibonacci LFSR feeds rejection-sampled (x, y) draws,
// with optional no-repeat, a bounded retry budget and a deterministic fallback commit.
module target_gen_lfsr #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                COORD_W   = 5,
  parameter int                X_MAX     = 31,
  parameter int                Y_MIN     = 30,
  parameter int                Y_OFF_W   = 1,
  parameter int                Y_SPAN    = 1,
  parameter int                MAX_TRIES = 8,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               start_new_game,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  output logic [COORD_W-1:0] target_x,
  output logic [COORD_W-1:0] target_y,
  output logic               target_valid,
  output logic               new_target,
  output logic               busy
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  state_t               state_q;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [TRY_W-1:0]     tries_q;
  logic [COORD_W-1:0]   target_x_q, target_y_q, fallback_x;
  logic                 target_valid_q, new_target_q, busy_q;

  logic [COORD_W-1:0]   x_c, y_c;
  logic [Y_OFF_W-1:0]   off_c;
  logic                 in_range, repeat_hit, accept, last_try;

  // seed_load wins over everything else and is honoured even with ena low
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load)
      lfsr_d = (seed == '0) ? SEED : seed;
    else if (lfsr_q == '0)
      lfsr_d = SEED;
    else if (ena)
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  end

  always_comb begin
    x_c        = lfsr_q[COORD_W-1:0];
    off_c      = lfsr_q[COORD_W+Y_OFF_W-1:COORD_W];
    y_c        = COORD_W'(Y_MIN) + COORD_W'(off_c);
    in_range   = (int'(x_c) <= X_MAX) && (int'(off_c) <= Y_SPAN);
    repeat_hit = NO_REPEAT && target_valid_q && (x_c == target_x_q) && (y_c == target_y_q);
    accept     = in_range && !repeat_hit;
    last_try   = (tries_q == TRY_W'(MAX_TRIES - 1));
    fallback_x = (target_x_q == COORD_W'(X_MAX)) ? '0 : target_x_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q         <= SEED;
      state_q        <= IDLE;
      tries_q        <= '0;
      target_x_q     <= '0;
      target_y_q     <= COORD_W'(Y_MIN);
      target_valid_q <= 1'b0;
      new_target_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      // With ena low the whole FSM, including the pulse output, is frozen
      if (ena) begin
        new_target_q <= 1'b0;
        case (state_q)
          IDLE, HOLD: begin
            if (start_new_game) begin
              state_q <= DRAW;
              tries_q <= '0;
              busy_q  <= 1'b1;
            end
          end
          DRAW: begin
            if (accept || last_try) begin
              target_x_q     <= accept ? x_c : fallback_x;
              target_y_q     <= accept ? y_c : target_y_q;
              target_valid_q <= 1'b1;
              new_target_q   <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= HOLD;
            end else begin
              tries_q <= tries_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign target_x     = target_x_q;
  assign target_y     = target_y_q;
  assign target_valid = target_valid_q;
  assign new_target   = new_target_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_target_gen_lfsr.sv
// Directed bench for target_gen_lfsr: three parameterisations share one stimulus stream,
// each checked against hand-derived LFSR sequences and commit results.
module tb_target_gen_lfsr;

  logic        clk = 1'b0;
  logic        reset, ena, start_new_game, seed_load;
  logic [15:0] seed;

  logic [4:0]  tx0, ty0, tx1, ty1, tx2, ty2;
  logic        tv0, nt0, bz0, tv1, nt1, bz1, tv2, nt2, bz2;

  int total = 0;
  int bad   = 0;
  int nt_cnt0 = 0, nt_cnt1 = 0, nt_cnt2 = 0;

  always #5 clk = ~clk;

  // Defaults
  target_gen_lfsr u_dut0 (
    .clk(clk), .reset(reset), .ena(ena), .start_new_game(start_new_game),
    .seed_load(seed_load), .seed(seed),
    .target_x(tx0), .target_y(ty0), .target_valid(tv0), .new_target(nt0), .busy(bz0)
  );

  // Narrow x range: several rejections before an accept
  target_gen_lfsr #(.X_MAX(19)) u_dut1 (
    .clk(clk), .reset(reset), .ena(ena), .start_new_game(start_new_game),
    .seed_load(seed_load), .seed(seed),
    .target_x(tx1), .target_y(ty1), .target_valid(tv1), .new_target(nt1), .busy(bz1)
  );

  // Tiny range and budget: forces the fallback path
  target_gen_lfsr #(.X_MAX(3), .MAX_TRIES(2)) u_dut2 (
    .clk(clk), .reset(reset), .ena(ena), .start_new_game(start_new_game),
    .seed_load(seed_load), .seed(seed),
    .target_x(tx2), .target_y(ty2), .target_valid(tv2), .new_target(nt2), .busy(bz2)
  );

  always @(negedge clk) begin
    if (nt0) nt_cnt0++;
    if (nt1) nt_cnt1++;
    if (nt2) nt_cnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int          b0, b1, b2, n;
  bit          zero_seen;
  logic [15:0] first;

  initial begin
    reset = 1'b1; ena = 1'b1; start_new_game = 1'b0; seed_load = 1'b0; seed = '0;

    // Reset held for three cycles
    repeat (3) step();
    chk("rst_tx", tx0, 0);
    chk("rst_ty", ty0, 30);
    chk("rst_valid", tv0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_nt", nt0, 0);
    chk("rst_lfsr", u_dut0.lfsr_q, 16'hACE1);
    reset = 1'b0;
    step();
    chk("shift_ace1", u_dut0.lfsr_q, 16'h59C3);
    $display("txn reset/shift done");

    // Seed loads: plain value, feedback wrap, and zero replacement
    seed_load = 1'b1; seed = 16'h8000; step();
    chk("seed_8000", u_dut0.lfsr_q, 16'h8000);
    seed_load = 1'b0; step();
    chk("shift_8000", u_dut0.lfsr_q, 16'h0001);
    seed_load = 1'b1; seed = 16'h0000; ena = 1'b0; step();
    chk("seed_zero", u_dut0.lfsr_q, 16'hACE1);
    seed_load = 1'b0; ena = 1'b1;
    $display("txn seed_load done");

    // Seed 1 then start: first candidate is 0x0002
    do_reset();
    b0 = nt_cnt0;
    seed_load = 1'b1; seed = 16'h0001; step();
    seed_load = 1'b0; start_new_game = 1'b1; step();
    start_new_game = 1'b0;
    chk("c_busy", bz0, 1);
    chk("c_lfsr", u_dut0.lfsr_q, 16'h0002);
    step();
    chk("c_tx", tx0, 2);
    chk("c_ty", ty0, 30);
    chk("c_valid", tv0, 1);
    chk("c_nt", nt0, 1);
    chk("c_busy_done", bz0, 0);
    step();
    chk("c_nt_low", nt0, 0);
    chk("c_pulses", nt_cnt0 - b0, 1);
    $display("txn seed1 draw done");

    // Same seed again: (2,30) repeats, so the next candidate 0x0004 wins
    seed_load = 1'b1; seed = 16'h0001; step();
    seed_load = 1'b0; start_new_game = 1'b1; step();
    start_new_game = 1'b0; step();
    chk("nr_busy", bz0, 1);
    chk("nr_tx_hold", tx0, 2);
    step();
    chk("nr_tx", tx0, 4);
    chk("nr_ty", ty0, 30);
    $display("txn no-repeat done");

    // Seed 0x000F: dut0 accepts at once, dut1 after 3 rejects, dut2 falls back
    do_reset();
    b0 = nt_cnt0; b1 = nt_cnt1; b2 = nt_cnt2;
    seed_load = 1'b1; seed = 16'h000F; step();
    seed_load = 1'b0; start_new_game = 1'b1; step();
    start_new_game = 1'b0;
    n = 0;
    while (bz1 && n < 20) begin
      n++;
      step();
    end
    chk("d_busy_cycles", n, 4);
    chk("d1_tx", tx1, 16);
    chk("d1_ty", ty1, 31);
    chk("d1_valid", tv1, 1);
    chk("d0_tx", tx0, 30);
    chk("d0_ty", ty0, 30);
    chk("d2_tx", tx2, 1);
    chk("d2_ty", ty2, 30);
    chk("d2_valid", tv2, 1);
    step();
    chk("d0_pulses", nt_cnt0 - b0, 1);
    chk("d1_pulses", nt_cnt1 - b1, 1);
    chk("d2_pulses", nt_cnt2 - b2, 1);
    $display("txn reject/fallback done");

    // Freeze mid-DRAW, then a start while busy that must be ignored
    do_reset();
    b1 = nt_cnt1;
    seed_load = 1'b1; seed = 16'h000F; step();
    seed_load = 1'b0; start_new_game = 1'b1; step();
    start_new_game = 1'b0; step();
    ena = 1'b0; start_new_game = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("e_lfsr_frozen", u_dut1.lfsr_q, 16'h003C);
      chk("e_busy_frozen", bz1, 1);
      chk("e_valid_frozen", tv1, 0);
    end
    ena = 1'b1; step();
    start_new_game = 1'b0; step();
    chk("e_still_busy", bz1, 1);
    step();
    chk("e_tx", tx1, 16);
    chk("e_ty", ty1, 31);
    chk("e_busy_off", bz1, 0);
    step(); step();
    chk("e_no_relaunch", bz1, 0);
    chk("e_pulses", nt_cnt1 - b1, 1);
    $display("txn ena freeze done");

    // Reset during DRAW: the pending accept must not commit
    do_reset();
    b0 = nt_cnt0;
    seed_load = 1'b1; seed = 16'h000F; step();
    seed_load = 1'b0; start_new_game = 1'b1; step();
    start_new_game = 1'b0;
    chk("f_busy", bz0, 1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("f_valid", tv0, 0);
    chk("f_busy_off", bz0, 0);
    chk("f_nt", nt0, 0);
    chk("f_tx", tx0, 0);
    chk("f_ty", ty0, 30);
    step();
    chk("f_pulses", nt_cnt0 - b0, 0);
    $display("txn reset mid-draw done");

    // Full period walk from the reset seed
    do_reset();
    first = u_dut0.lfsr_q;
    n = 0;
    zero_seen = 1'b0;
    do begin
      step();
      n++;
      if (u_dut0.lfsr_q == 16'h0000) zero_seen = 1'b1;
    end while (u_dut0.lfsr_q != first && n < 70000);
    chk("g_period", n, 65535);
    chk("g_nonzero", zero_seen, 0);
    $display("txn period walk done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
